// File: rtl/fpu_normalizer.sv
// Post-arithmetic normalizer for the binary32 FPU back end: moves the leading one
// into bit 23, adjusts the biased exponent, and flags overflow or flush-to-zero.
module fpu_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [23:0] mantissa,
    input  logic [7:0]  exponent,
    output logic        out_valid,
    output logic [22:0] normalized_mantissa,
    output logic [7:0]  normalized_exponent,
    output logic        overflow_underflow_flag
);

    logic [23:0] mant_q;
    logic [7:0]  exp_q;
    logic        valid_q;

    logic [4:0]  lz;
    logic [8:0]  exp_diff;
    logic [23:0] shifted;

    // Inputs are captured only on valid cycles, so the outputs hold between samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q  <= '0;
            exp_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                mant_q <= mantissa;
                exp_q  <= exponent;
            end
        end
    end

    always_comb begin
        lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (mant_q[i]) begin
                lz = 5'(23 - i);
            end
        end
    end

    // A borrow or a zero difference both mean the result exponent would be <= 0.
    assign exp_diff = {1'b0, exp_q} - {4'b0000, lz};
    assign shifted  = mant_q << lz;

    always_comb begin
        normalized_mantissa     = '0;
        normalized_exponent     = '0;
        overflow_underflow_flag = 1'b0;
        if (exp_q == 8'hFF) begin
            normalized_exponent     = 8'hFF;
            overflow_underflow_flag = 1'b1;
        end else if (mant_q == 24'd0) begin
            overflow_underflow_flag = 1'b0;
        end else if (exp_diff[8] || (exp_diff == 9'd0)) begin
            overflow_underflow_flag = 1'b1;
        end else begin
            normalized_mantissa = shifted[22:0];
            normalized_exponent = exp_diff[7:0];
        end
    end

    assign out_valid = valid_q;

endmodule

// File: tb/tb_fpu_normalizer.sv
// Scoreboard bench for fpu_normalizer: expected results come from an independent
// behavioural model, are queued at drive time and popped when out_valid appears.
module tb_fpu_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] mantissa;
    logic [7:0]  exponent;
    logic        out_valid;
    logic [22:0] normalized_mantissa;
    logic [7:0]  normalized_exponent;
    logic        overflow_underflow_flag;

    logic [31:0] sb[$];
    logic [31:0] exp_word;
    logic [31:0] last_word;
    int          compared;
    int          mismatched;

    fpu_normalizer dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .in_valid                (in_valid),
        .mantissa                (mantissa),
        .exponent                (exponent),
        .out_valid               (out_valid),
        .normalized_mantissa     (normalized_mantissa),
        .normalized_exponent     (normalized_exponent),
        .overflow_underflow_flag (overflow_underflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result packed as {frac[22:0], exp[7:0], flag}.
    function automatic logic [31:0] model(input logic [23:0] m, input logic [7:0] e);
        int          lzc;
        logic [23:0] sh;
        lzc = 24;
        for (int i = 23; i >= 0; i--) begin
            if (m[i]) begin
                lzc = 23 - i;
                break;
            end
        end
        if (e == 8'hFF) return {23'd0, 8'hFF, 1'b1};
        if (m == 24'd0) return 32'd0;
        if (int'(e) <= lzc) return {23'd0, 8'd0, 1'b1};
        sh = m << lzc;
        return {sh[22:0], 8'(int'(e) - lzc), 1'b0};
    endfunction

    function automatic logic [31:0] observed();
        return {normalized_mantissa, normalized_exponent, overflow_underflow_flag};
    endfunction

    task automatic drive(input logic [23:0] m, input logic [7:0] e);
        in_valid = 1'b1;
        mantissa = m;
        exponent = e;
        sb.push_back(model(m, e));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        mantissa = 24'($urandom);
        exponent = 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #12;
        compared++;
        if ({out_valid, observed()} !== 33'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %h, want 0", {out_valid, observed()});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_table();
        logic [23:0] ms[12] = '{24'h000001, 24'h000001, 24'h000002, 24'h100000, 24'h100000,
                                24'h400000, 24'h5A0000, 24'h800000, 24'hFFFFFF, 24'h000000,
                                24'h000003, 24'h0000FF};
        logic [7:0]  es[12] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd10, 8'd5, 8'hFF, 8'd77,
                                8'd200, 8'd17};
        for (int i = 0; i < 12; i++) begin
            drive(ms[i], es[i]);
            tick();
            idle();
            compared++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL table_valid[%0d]: got %b, want 1", i, out_valid);
            end else begin
                exp_word = sb.pop_front();
                compared++;
                if (observed() !== exp_word) begin
                    mismatched++;
                    $display("[TB] FAIL table[%0d]: got %h, want %h", i, observed(), exp_word);
                end
            end
        end
    endtask

    task automatic test_hold();
        drive(24'h5A0000, 8'd10);
        last_word = sb[sb.size()-1];
        tick();
        void'(sb.pop_front());
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (out_valid !== 1'b0 || observed() !== last_word) begin
                mismatched++;
                $display("[TB] FAIL hold[%0d]: got v=%b %h, want v=0 %h",
                         i, out_valid, observed(), last_word);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                drive(24'($urandom) >> $urandom_range(0, 24),
                      ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 40)));
            end
            tick();
            if (out_valid === 1'b1) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_extra[%0d]: out_valid with empty scoreboard", i);
                end else begin
                    exp_word = sb.pop_front();
                    if (observed() !== exp_word) begin
                        mismatched++;
                        $display("[TB] FAIL b2b[%0d]: got %h, want %h", i, observed(), exp_word);
                    end
                end
            end
        end
        idle();
        tick();
        if (out_valid === 1'b1 && sb.size() != 0) begin
            exp_word = sb.pop_front();
            compared++;
            if (observed() !== exp_word) begin
                mismatched++;
                $display("[TB] FAIL b2b_tail: got %h, want %h", observed(), exp_word);
            end
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_drain: got %0d left, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_midstream();
        drive(24'h400000, 8'd4);
        tick();
        drive(24'h000000, 8'd77);
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        compared++;
        if ({out_valid, observed()} !== 33'd0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got %h, want 0", {out_valid, observed()});
        end
        idle();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (out_valid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL post_reset_idle[%0d]: got %b, want 0", i, out_valid);
            end
        end
        drive(24'h800000, 8'd5);
        tick();
        idle();
        exp_word = sb.pop_front();
        compared++;
        if (out_valid !== 1'b1 || observed() !== exp_word) begin
            mismatched++;
            $display("[TB] FAIL post_reset_first: got v=%b %h, want v=1 %h",
                     out_valid, observed(), exp_word);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_table();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
